// File: rtl/axis_cobs_decoder_pkg.sv
// Shared AXI-Stream COBS definitions: decoder state encoding and framing constants.
package axis_cobs_decoder_pkg;

    typedef enum logic [1:0] {
        ST_CODE,
        ST_DATA,
        ST_DISCARD
    } cobs_dec_state_t;

    localparam logic [7:0] COBS_DELIM    = 8'h00;
    localparam logic [7:0] COBS_MAX_CODE = 8'hFF;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } axis_beat_t;

endpackage

// File: rtl/axis_cobs_decoder_if.sv
// Byte-wide AXI-Stream bundle; sink receives a stream, source produces one.
interface axis_interface;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport sink   (input tdata, tvalid, tlast, tuser, output tready);
    modport source (output tdata, tvalid, tlast, tuser, input tready);
endinterface

// File: rtl/axis_cobs_decode_wrapper.sv
// Adapts the COBS decoder's flat ports to axis_interface sink/source bundles.
module axis_cobs_decode_wrapper #(
    parameter int MAX_FRAME_LEN = 2048
) (
    input  logic          clk,
    input  logic          reset,
    axis_interface.sink   snk,
    axis_interface.source src,
    output logic          frame_done,
    output logic          frame_error
);
    logic unused_tuser;
    assign unused_tuser = snk.tuser;

    axis_cobs_decoder #(.MAX_FRAME_LEN(MAX_FRAME_LEN)) u_dec (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (snk.tdata),
        .s_axis_tvalid (snk.tvalid),
        .s_axis_tready (snk.tready),
        .s_axis_tlast  (snk.tlast),
        .m_axis_tdata  (src.tdata),
        .m_axis_tvalid (src.tvalid),
        .m_axis_tready (src.tready),
        .m_axis_tlast  (src.tlast),
        .m_axis_tuser  (src.tuser),
        .frame_done    (frame_done),
        .frame_error   (frame_error)
    );
endmodule

// File: rtl/axis_cobs_decoder.sv
// COBS frame decoder: 0x00-delimited encoded bytes in, decoded frame bytes out with
// tlast on the final byte and tuser flagging truncated or oversize frames.
module axis_cobs_decoder
    import axis_cobs_decoder_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       frame_done,
    output logic       frame_error
);
    localparam int LEN_W = $clog2(MAX_FRAME_LEN + 2);

    cobs_dec_state_t  state, state_nxt;
    logic [7:0]       remaining, remaining_nxt;
    logic             blk_max, blk_max_nxt;
    logic             pend_zero, pend_zero_nxt;
    logic             hold_vld, hold_vld_nxt;
    logic [7:0]       hold_data, hold_data_nxt;
    logic [LEN_W-1:0] len_cnt, len_cnt_nxt;
    logic             accept, is_delim, dec_vld, out_load, done_nxt, err_nxt;
    logic [7:0]       dec_data;
    axis_beat_t       out_beat;
    logic             unused_tlast;

    // Framing comes only from delimiters, so the input tlast is deliberately ignored.
    assign unused_tlast  = s_axis_tlast;
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign is_delim      = (s_axis_tdata == COBS_DELIM);

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        blk_max_nxt   = blk_max;
        pend_zero_nxt = pend_zero;
        hold_vld_nxt  = hold_vld;
        hold_data_nxt = hold_data;
        len_cnt_nxt   = len_cnt;
        out_load      = 1'b0;
        out_beat      = '{data: hold_data, last: 1'b0, user: 1'b0};
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        dec_vld       = 1'b0;
        dec_data      = s_axis_tdata;
        if (accept) begin
            if (is_delim) begin
                // Still inside a block means the frame ended early.
                done_nxt      = 1'b1;
                err_nxt       = (state == ST_DATA);
                out_load      = hold_vld;
                out_beat.last = 1'b1;
                out_beat.user = (state == ST_DATA);
                state_nxt     = ST_CODE;
                remaining_nxt = 8'd0;
                pend_zero_nxt = 1'b0;
                hold_vld_nxt  = 1'b0;
                len_cnt_nxt   = '0;
            end else begin
                case (state)
                    ST_CODE: begin
                        dec_vld       = pend_zero;
                        dec_data      = COBS_DELIM;
                        remaining_nxt = s_axis_tdata - 8'd1;
                        blk_max_nxt   = (s_axis_tdata == COBS_MAX_CODE);
                        pend_zero_nxt = (s_axis_tdata == 8'd1);
                        state_nxt     = (s_axis_tdata == 8'd1) ? ST_CODE : ST_DATA;
                    end
                    ST_DATA: begin
                        dec_vld       = 1'b1;
                        remaining_nxt = remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state_nxt     = ST_CODE;
                            pend_zero_nxt = !blk_max;
                        end
                    end
                    default: ;
                endcase
                if (dec_vld) begin
                    if (len_cnt == LEN_W'(MAX_FRAME_LEN)) begin
                        out_load      = hold_vld;
                        out_beat.last = 1'b1;
                        out_beat.user = 1'b1;
                        err_nxt       = 1'b1;
                        hold_vld_nxt  = 1'b0;
                        pend_zero_nxt = 1'b0;
                        state_nxt     = ST_DISCARD;
                    end else begin
                        out_load      = hold_vld;
                        hold_vld_nxt  = 1'b1;
                        hold_data_nxt = dec_data;
                        len_cnt_nxt   = len_cnt + LEN_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_CODE;
            remaining     <= 8'd0;
            blk_max       <= 1'b0;
            pend_zero     <= 1'b0;
            hold_vld      <= 1'b0;
            hold_data     <= 8'd0;
            len_cnt       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'd0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_done    <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state       <= state_nxt;
            remaining   <= remaining_nxt;
            blk_max     <= blk_max_nxt;
            pend_zero   <= pend_zero_nxt;
            hold_vld    <= hold_vld_nxt;
            hold_data   <= hold_data_nxt;
            len_cnt     <= len_cnt_nxt;
            frame_done  <= done_nxt;
            frame_error <= err_nxt;
            // A load only happens on an accepted input, which implies the output slot is free.
            if (out_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= out_beat.data;
                m_axis_tlast  <= out_beat.last;
                m_axis_tuser  <= out_beat.user;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_cobs_decoder.sv
// Randomized self-checking bench for axis_cobs_decoder against a frame-level COBS model.
module tb_axis_cobs_decoder;
    localparam int MAXL = 300;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axis_interface in_if();
    axis_interface out_if();
    axis_interface w_in();
    axis_interface w_out();
    logic frame_done, frame_error, w_done, w_err;

    axis_cobs_decoder #(.MAX_FRAME_LEN(MAXL)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (in_if.tdata),
        .s_axis_tvalid (in_if.tvalid),
        .s_axis_tready (in_if.tready),
        .s_axis_tlast  (in_if.tlast),
        .m_axis_tdata  (out_if.tdata),
        .m_axis_tvalid (out_if.tvalid),
        .m_axis_tready (out_if.tready),
        .m_axis_tlast  (out_if.tlast),
        .m_axis_tuser  (out_if.tuser),
        .frame_done    (frame_done),
        .frame_error   (frame_error)
    );

    assign w_in.tdata   = in_if.tdata;
    assign w_in.tvalid  = in_if.tvalid;
    assign w_in.tlast   = in_if.tlast;
    assign w_in.tuser   = 1'b0;
    assign w_out.tready = out_if.tready;
    axis_cobs_decode_wrapper #(.MAX_FRAME_LEN(MAXL)) wrap (
        .clk         (clk),
        .reset       (reset),
        .snk         (w_in.sink),
        .src         (w_out.source),
        .frame_done  (w_done),
        .frame_error (w_err)
    );
    logic unused_wrap;
    assign unused_wrap = ^{w_out.tdata, w_out.tvalid, w_out.tlast, w_out.tuser, w_done, w_err,
                           w_in.tready, in_if.tuser};

    int vectors = 0;
    int miscompares = 0;
    int ready_pct = 100;
    int gap_pct = 0;

    // Captured output beats and pulse counts
    bq_t  got_d;
    logic got_l[$];
    logic got_u[$];
    int   done_cnt, err_cnt;
    logic stall_q = 1'b0;
    logic [9:0] stall_beat;

    // Expected results from the model
    bq_t  exp_d;
    logic exp_l[$];
    logic exp_u[$];
    int   exp_done, exp_err;

    always @(negedge clk) begin
        if (stall_q) begin
            vectors++;
            if (out_if.tvalid !== 1'b1 || {out_if.tdata, out_if.tlast, out_if.tuser} !== stall_beat) begin
                miscompares++;
                $display("FAIL stall_hold: got v%b %h/l%b/u%b, expected held %h/l%b/u%b", out_if.tvalid,
                         out_if.tdata, out_if.tlast, out_if.tuser, stall_beat[9:2], stall_beat[1], stall_beat[0]);
            end
        end
        out_if.tready = ($urandom_range(99) < ready_pct);
        if (out_if.tvalid === 1'b1 && out_if.tready) begin
            got_d.push_back(out_if.tdata);
            got_l.push_back(out_if.tlast);
            got_u.push_back(out_if.tuser);
        end
        stall_q    = (out_if.tvalid === 1'b1) && !out_if.tready && !reset;
        stall_beat = {out_if.tdata, out_if.tlast, out_if.tuser};
        if (frame_done === 1'b1) done_cnt++;
        if (frame_error === 1'b1) err_cnt++;
    end

    // COBS decode of one frame (bytes between delimiters), expressed on whole byte lists.
    function automatic void model_frame(bq_t f);
        bq_t dec;
        bit  trunc = 1'b0;
        int  i = 0;
        int  code;
        while (i < f.size()) begin
            code = int'(f[i]);
            i++;
            for (int j = 1; j < code; j++) begin
                if (i >= f.size()) begin
                    trunc = 1'b1;
                    break;
                end
                dec.push_back(f[i]);
                i++;
            end
            if (code < 255 && i < f.size()) dec.push_back(8'h00);
        end
        exp_done++;
        if (dec.size() > MAXL) begin
            dec   = dec[0:MAXL-1];
            trunc = 1'b1;
        end
        if (trunc) exp_err++;
        foreach (dec[k]) begin
            exp_d.push_back(dec[k]);
            exp_l.push_back(k == dec.size() - 1);
            exp_u.push_back(trunc && (k == dec.size() - 1));
        end
    endfunction

    function automatic void model_stream(bq_t s);
        bq_t f;
        foreach (s[k]) begin
            if (s[k] == 8'h00) begin
                model_frame(f);
                f = {};
            end else begin
                f.push_back(s[k]);
            end
        end
    endfunction

    function automatic void clear_all();
        got_d = {}; got_l = {}; got_u = {};
        exp_d = {}; exp_l = {}; exp_u = {};
        done_cnt = 0; err_cnt = 0; exp_done = 0; exp_err = 0;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        while ($urandom_range(99) < gap_pct) begin
            @(negedge clk);
            in_if.tvalid = 1'b0;
        end
        @(negedge clk);
        in_if.tdata  = b;
        in_if.tvalid = 1'b1;
        #2;
        while (in_if.tready !== 1'b1) begin
            @(negedge clk);
            #2;
            guard++;
            if (guard > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL s_ready_timeout: got tready=%b after %0d cycles, expected 1", in_if.tready, guard);
                break;
            end
        end
    endtask

    task automatic send_stream(input bq_t s);
        foreach (s[k]) send_byte(s[k]);
        @(negedge clk);
        in_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        repeat (3) @(negedge clk);
        while (out_if.tvalid === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        if (n >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got tvalid still high after %0d cycles, expected 0", n);
        end
    endtask

    task automatic run(input bq_t s);
        clear_all();
        model_stream(s);
        send_stream(s);
        drain();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (out_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b, expected 0", out_if.tvalid); end
        vectors++; if (out_if.tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b, expected 0", out_if.tlast); end
        vectors++; if (out_if.tuser !== 1'b0) begin miscompares++; $display("FAIL reset_tuser: got %b, expected 0", out_if.tuser); end
        vectors++; if (out_if.tdata !== 8'h00) begin miscompares++; $display("FAIL reset_tdata: got %h, expected 00", out_if.tdata); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", frame_done); end
        vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b, expected 0", frame_error); end
        vectors++; if (in_if.tready !== 1'b1) begin miscompares++; $display("FAIL reset_sready: got %b, expected 1", in_if.tready); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bq_t s = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        run(s);
        vectors++;
        if (exp_d.size() != 4 || got_d.size() != exp_d.size()) begin miscompares++; $display("FAIL basic_count: got %0d beats, expected %0d (model %0d)", got_d.size(), 4, exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if ({got_d[i], got_l[i], got_u[i]} !== {exp_d[i], exp_l[i], exp_u[i]}) begin miscompares++; $display("FAIL basic_beat%0d: got %h/l%b/u%b, expected %h/l%b/u%b", i, got_d[i], got_l[i], got_u[i], exp_d[i], exp_l[i], exp_u[i]); end
        end
        vectors++;
        if (done_cnt !== 1 || err_cnt !== 0) begin miscompares++; $display("FAIL basic_pulses: got done=%0d err=%0d, expected done=1 err=0", done_cnt, err_cnt); end
    endtask

    task automatic test_zero_frames();
        bq_t s = '{8'h01, 8'h01, 8'h00, 8'h00};
        run(s);
        vectors++;
        if (got_d.size() !== 1) begin miscompares++; $display("FAIL zero_count: got %0d beats, expected 1", got_d.size()); end
        else begin
            vectors++;
            if ({got_d[0], got_l[0], got_u[0]} !== {8'h00, 1'b1, 1'b0}) begin miscompares++; $display("FAIL zero_beat: got %h/l%b/u%b, expected 00/l1/u0", got_d[0], got_l[0], got_u[0]); end
        end
        vectors++;
        if (done_cnt !== exp_done || done_cnt !== 2 || err_cnt !== 0) begin miscompares++; $display("FAIL zero_pulses: got done=%0d err=%0d, expected done=2 err=0", done_cnt, err_cnt); end
    endtask

    task automatic test_long_block();
        bq_t s;
        s.push_back(8'hFF);
        for (int v = 1; v <= 254; v++) s.push_back(8'(v));
        s.push_back(8'h00);
        run(s);
        vectors++;
        if (got_d.size() !== 254) begin miscompares++; $display("FAIL long_count: got %0d beats, expected 254", got_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if ({got_d[i], got_l[i], got_u[i]} !== {exp_d[i], exp_l[i], exp_u[i]}) begin miscompares++; $display("FAIL long_beat%0d: got %h/l%b/u%b, expected %h/l%b/u%b", i, got_d[i], got_l[i], got_u[i], exp_d[i], exp_l[i], exp_u[i]); end
        end
    endtask

    task automatic test_truncated();
        bq_t s = '{8'h05, 8'hAA, 8'hBB, 8'h00, 8'h02, 8'h44, 8'h00};
        run(s);
        vectors++;
        if (got_d.size() !== exp_d.size()) begin miscompares++; $display("FAIL trunc_count: got %0d beats, expected %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if ({got_d[i], got_l[i], got_u[i]} !== {exp_d[i], exp_l[i], exp_u[i]}) begin miscompares++; $display("FAIL trunc_beat%0d: got %h/l%b/u%b, expected %h/l%b/u%b", i, got_d[i], got_l[i], got_u[i], exp_d[i], exp_l[i], exp_u[i]); end
        end
        vectors++;
        if (err_cnt !== 1 || done_cnt !== 2) begin miscompares++; $display("FAIL trunc_pulses: got done=%0d err=%0d, expected done=2 err=1", done_cnt, err_cnt); end
    endtask

    task automatic test_backpressure();
        bq_t s;
        for (int r = 0; r < 4; r++) s = {s, 8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        ready_pct = 30;
        run(s);
        ready_pct = 100;
        vectors++;
        if (got_d.size() !== exp_d.size()) begin miscompares++; $display("FAIL bp_count: got %0d beats, expected %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if ({got_d[i], got_l[i], got_u[i]} !== {exp_d[i], exp_l[i], exp_u[i]}) begin miscompares++; $display("FAIL bp_beat%0d: got %h/l%b/u%b, expected %h/l%b/u%b", i, got_d[i], got_l[i], got_u[i], exp_d[i], exp_l[i], exp_u[i]); end
        end
        vectors++;
        if (done_cnt !== exp_done) begin miscompares++; $display("FAIL bp_done: got %0d, expected %0d", done_cnt, exp_done); end
    endtask

    task automatic test_reset_midframe();
        bq_t pre = '{8'h03, 8'h11};
        bq_t s = '{8'h02, 8'h55, 8'h00};
        clear_all();
        send_stream(pre);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_stream(s);
        send_stream(s);
        drain();
        vectors++;
        if (got_d.size() !== 1) begin miscompares++; $display("FAIL rstmid_count: got %0d beats, expected 1", got_d.size()); end
        else begin
            vectors++;
            if ({got_d[0], got_l[0], got_u[0]} !== {exp_d[0], exp_l[0], exp_u[0]}) begin miscompares++; $display("FAIL rstmid_beat: got %h/l%b/u%b, expected %h/l%b/u%b", got_d[0], got_l[0], got_u[0], exp_d[0], exp_l[0], exp_u[0]); end
        end
    endtask

    task automatic test_oversize();
        bq_t s;
        // Exactly MAXL decoded bytes: 254 + 46.
        s.push_back(8'hFF);
        for (int v = 0; v < 254; v++) s.push_back(8'($urandom_range(255, 1)));
        s.push_back(8'd47);
        for (int v = 0; v < 46; v++) s.push_back(8'($urandom_range(255, 1)));
        s.push_back(8'h00);
        // MAXL+1 decoded bytes: 254 + 47.
        s.push_back(8'hFF);
        for (int v = 0; v < 254; v++) s.push_back(8'($urandom_range(255, 1)));
        s.push_back(8'd48);
        for (int v = 0; v < 47; v++) s.push_back(8'($urandom_range(255, 1)));
        s.push_back(8'h00);
        s = {s, 8'h02, 8'h44, 8'h00};
        run(s);
        vectors++;
        if (got_d.size() !== exp_d.size() || exp_d.size() != 2 * MAXL + 1) begin miscompares++; $display("FAIL over_count: got %0d beats, expected %0d", got_d.size(), 2 * MAXL + 1); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if ({got_d[i], got_l[i], got_u[i]} !== {exp_d[i], exp_l[i], exp_u[i]}) begin miscompares++; $display("FAIL over_beat%0d: got %h/l%b/u%b, expected %h/l%b/u%b", i, got_d[i], got_l[i], got_u[i], exp_d[i], exp_l[i], exp_u[i]); end
        end
        vectors++;
        if (err_cnt !== 1 || done_cnt !== 3) begin miscompares++; $display("FAIL over_pulses: got done=%0d err=%0d, expected done=3 err=1", done_cnt, err_cnt); end
    endtask

    task automatic test_random_back_to_back();
        bq_t s;
        int len;
        for (int fr = 0; fr < 24; fr++) begin
            len = $urandom_range(40);
            for (int k = 0; k < len; k++)
                s.push_back(($urandom_range(1) == 0) ? 8'($urandom_range(6, 1)) : 8'($urandom_range(255, 1)));
            s.push_back(8'h00);
        end
        gap_pct   = 20;
        ready_pct = 60;
        run(s);
        gap_pct   = 0;
        ready_pct = 100;
        vectors++;
        if (got_d.size() !== exp_d.size()) begin miscompares++; $display("FAIL rand_count: got %0d beats, expected %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if ({got_d[i], got_l[i], got_u[i]} !== {exp_d[i], exp_l[i], exp_u[i]}) begin miscompares++; $display("FAIL rand_beat%0d: got %h/l%b/u%b, expected %h/l%b/u%b", i, got_d[i], got_l[i], got_u[i], exp_d[i], exp_l[i], exp_u[i]); end
        end
        vectors++;
        if (done_cnt !== exp_done || err_cnt !== exp_err) begin miscompares++; $display("FAIL rand_pulses: got done=%0d err=%0d, expected done=%0d err=%0d", done_cnt, err_cnt, exp_done, exp_err); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by time limit, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_if.tdata   = 8'h00;
        in_if.tvalid  = 1'b0;
        in_if.tlast   = 1'b0;
        in_if.tuser   = 1'b0;
        out_if.tready = 1'b1;
        test_reset();
        test_basic();
        test_zero_frames();
        test_long_block();
        test_truncated();
        test_backpressure();
        test_reset_midframe();
        test_oversize();
        test_random_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axis_cobs_decoder.md
AXIS_COBS_DECODER -- requirements
Module: axis_cobs_decoder

Interface
REQ-001 SHALL have parameter MAX_FRAME_LEN, default 2048, giving the maximum decoded bytes per frame.
REQ-002 SHALL have port clk, input, 1: sole clock.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port s_axis_tdata, input, 8: COBS-encoded byte.
REQ-005 SHALL have port s_axis_tvalid, input, 1: encoded byte valid.
REQ-006 SHALL have port s_axis_tready, output, 1: decoder accepts the byte.
REQ-007 SHALL have port s_axis_tlast, input, 1: ignored; framing comes only from 0x00 delimiters.
REQ-008 SHALL have port m_axis_tdata, output, 8: decoded byte.
REQ-009 SHALL have port m_axis_tvalid, output, 1: decoded byte valid.
REQ-010 SHALL have port m_axis_tready, input, 1: downstream accepts.
REQ-011 SHALL have port m_axis_tlast, output, 1: last decoded byte of the frame.
REQ-012 SHALL have port m_axis_tuser, output, 1: frame in error; valid only with tlast.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse when a delimiter is consumed.
REQ-014 SHALL have port frame_error, output, 1: one-cycle pulse when a truncated or oversize frame is detected.

Function
REQ-015 SHALL consume an input byte only on s_axis_tvalid && s_axis_tready; s_axis_tready = !m_axis_tvalid || m_axis_tready.
REQ-016 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tuser stable while m_axis_tvalid && !m_axis_tready.
REQ-017 SHALL implement states CODE (expect code byte), DATA (inside block, 8-bit remaining count), and DISCARD (drop until delimiter).
REQ-018 In CODE, a nonzero byte N SHALL set remaining = N-1 and go to DATA (stay in CODE if N=1).
REQ-019 In CODE, if a pending-zero flag is set, a nonzero code byte SHALL first produce one decoded 0x00.
REQ-020 Leaving a block with N<0xFF SHALL set pending-zero; leaving with N=0xFF SHALL clear it.
REQ-021 In DATA, a nonzero byte SHALL produce that byte and decrement remaining; remaining reaching 0 SHALL return to CODE.
REQ-022 A 0x00 byte in any state SHALL be the delimiter: clear pending-zero, pulse frame_done, return to CODE.
REQ-023 A delimiter in DATA with remaining>0 SHALL mark the frame truncated: tuser=1 on the tlast byte, frame_error pulsed.
REQ-024 Each decoded byte SHALL first enter a one-byte hold register; on the next decoded byte, the held byte moves to the m_axis register with tlast=0.
REQ-025 On a delimiter, the held byte (if any) SHALL move to the m_axis register with tlast=1.
REQ-026 A delimiter with an empty hold (e.g. 00, or 01 00) SHALL emit nothing but still pulse frame_done (and frame_error if truncated).
REQ-027 Throughput SHALL be one input byte per cycle with no backpressure; each input byte produces at most one decoded byte.
REQ-028 Decoded byte MAX_FRAME_LEN+1 SHALL cause:
- the held byte to be emitted with tlast=1 and tuser=1;
- frame_error to pulse;
- entry to DISCARD.
REQ-029 DISCARD SHALL drop all nonzero bytes; the delimiter returns to CODE with no output.
REQ-030 The frame length counter SHALL be $clog2(MAX_FRAME_LEN+2) bits and clear on every delimiter.

Reset
REQ-031 On reset the following SHALL hold:
- state=CODE; remaining, pending-zero, hold-valid and the length counter cleared;
- m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done and frame_error = 0;
- m_axis_tdata = 0x00.
REQ-032 Reset mid-frame SHALL discard all partial and held data; the first byte after reset is treated as a code byte.

Structure
REQ-033 The shared axis package SHALL hold the state enum cobs_dec_state_t and the constants COBS_DELIM=8'h00 and COBS_MAX_CODE=8'hFF.
REQ-034 SHALL be a single module with no sub-modules.
REQ-035 An axis_cobs_decode_wrapper SHALL adapt the ports to axis_interface Sink/Source, mirroring the encoder wrapper.

Verification
REQ-036 Input 03 11 22 02 33 00 -> output 11 22 00 33, tlast on 33, tuser=0, one frame_done pulse.
REQ-037 Input 01 01 00 -> single output 00 with tlast=1; input 00 alone -> no output, frame_done pulses.
REQ-038 Input FF, 01..FE, 00 -> 254 bytes 01..FE, no trailing 00, tlast on FE.
REQ-039 Input 05 AA BB 00 -> output AA BB, tlast=1 and tuser=1 on BB, frame_error pulses once; the next frame 02 44 00 decodes to 44 with tuser=0.
REQ-040 With m_axis_tready random at 30% duty on the REQ-036 stream -> identical output and no lost or duplicated bytes.
REQ-041 Reset asserted after 03 11 -> no output; the following 02 55 00 -> output 55 with tlast=1.
